// File: rtl/shft_pkg.sv
// Shared constants and mode encoding for the 8-bit loadable shift register.
package shft_pkg;

    localparam int unsigned WIDTH = 8;
    localparam logic [WIDTH-1:0] Q_RST = 8'h00;

    // Shift mode selector for setting ROTATE in parent designs.
    typedef enum logic {
        SHIFT_LOGICAL = 1'b0,
        SHIFT_ROTATE  = 1'b1
    } shift_mode_e;

endpackage : shft_pkg

// File: rtl/shft_reg_8bit.sv
// 8-bit loadable right-shift register; loads N into q[7:1], then shifts or rotates right.
module shft_reg_8bit
    import shft_pkg::*;
#(
    parameter bit ROTATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             shft,
    input  logic [7:1]       N,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;
    logic             w_fill;

    // Bit shifted into q[7]: zero for a logical shift, the outgoing q[0] when rotating.
    assign w_fill = ROTATE ? r_q[0] : 1'b0;

    // State register: async reset, then load has priority over shift, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= Q_RST;
        end else if (start) begin
            r_q <= {N, 1'b0};
        end else if (shft) begin
            r_q <= {w_fill, r_q[WIDTH-1:1]};
        end
    end

    assign q = r_q;

endmodule : shft_reg_8bit

// File: tb/tb_shft_reg_8bit.sv
// Directed bench: one logical-shift and one rotating instance driven by shared controls.
module tb_shft_reg_8bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       shft;
    logic [7:1] N;
    logic [7:0] q_log;
    logic [7:0] q_rot;

    int total = 0;
    int bad   = 0;

    shft_reg_8bit #(.ROTATE(1'b0)) dut_log (
        .clk(clk), .rst_n(rst_n), .start(start), .shft(shft), .N(N), .q(q_log)
    );

    shft_reg_8bit #(.ROTATE(1'b1)) dut_rot (
        .clk(clk), .rst_n(rst_n), .start(start), .shft(shft), .N(N), .q(q_rot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        start = 1'b0; shft = 1'b0; N = 7'd0; rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (q_log !== 8'h00 || q_rot !== 8'h00) begin
            bad++; $display("FAIL reset_immediate log=%h rot=%h expected 00", q_log, q_rot);
        end
        #97;
        total++;
        if (q_log !== 8'h00 || q_rot !== 8'h00) begin
            bad++; $display("FAIL reset_held log=%h rot=%h expected 00", q_log, q_rot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (q_log !== 8'h00 || q_rot !== 8'h00) begin
                bad++; $display("FAIL reset_release_idle%0d log=%h rot=%h expected 00", i, q_log, q_rot);
            end
        end
    endtask

    task automatic test_load();
        N = 7'b1011001; start = 1'b1; shft = 1'b0;
        step();
        start = 1'b0;
        total++;
        if (q_log !== 8'b10110010 || q_rot !== 8'b10110010) begin
            bad++; $display("FAIL load log=%b rot=%b expected 10110010", q_log, q_rot);
        end
        for (int i = 0; i < 5; i++) begin
            N = 7'(i * 23 + 5);
            step();
            total++;
            if (q_log !== 8'b10110010 || q_rot !== 8'b10110010) begin
                bad++; $display("FAIL hold%0d log=%b rot=%b expected 10110010", i, q_log, q_rot);
            end
        end
    endtask

    task automatic test_logical_shift();
        logic [7:0] exp_log [8];
        logic [7:0] exp_rot [8];
        exp_log = '{8'b01011001, 8'b00101100, 8'b00010110, 8'b00001011,
                    8'b00000101, 8'b00000010, 8'b00000001, 8'b00000000};
        exp_rot = '{8'b01011001, 8'b10101100, 8'b01010110, 8'b00101011,
                    8'b10010101, 8'b11001010, 8'b01100101, 8'b10110010};
        shft = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (q_log !== exp_log[i]) begin
                bad++; $display("FAIL lshift%0d got=%b expected %b", i + 1, q_log, exp_log[i]);
            end
            total++;
            if (q_rot !== exp_rot[i]) begin
                bad++; $display("FAIL rshift%0d got=%b expected %b", i + 1, q_rot, exp_rot[i]);
            end
        end
        step();
        shft = 1'b0;
        total++;
        if (q_log !== 8'h00) begin
            bad++; $display("FAIL lshift_zero got=%b expected 00000000", q_log);
        end
    endtask

    task automatic test_rotate();
        N = 7'b1000001; start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (q_rot !== 8'b10000010 || q_log !== 8'b10000010) begin
            bad++; $display("FAIL rot_load log=%b rot=%b expected 10000010", q_log, q_rot);
        end
        shft = 1'b1;
        step();
        total++;
        if (q_rot !== 8'b01000001 || q_log !== 8'b01000001) begin
            bad++; $display("FAIL rot_s1 log=%b rot=%b expected 01000001", q_log, q_rot);
        end
        step();
        total++;
        if (q_rot !== 8'b10100000 || q_log !== 8'b00100000) begin
            bad++; $display("FAIL rot_s2 log=%b rot=%b expected 00100000/10100000", q_log, q_rot);
        end
        for (int i = 0; i < 6; i++) step();
        shft = 1'b0;
        total++;
        if (q_rot !== 8'b10000010 || q_log !== 8'h00) begin
            bad++; $display("FAIL rot_s8 log=%b rot=%b expected 00000000/10000010", q_log, q_rot);
        end
    endtask

    task automatic test_priority();
        N = 7'b1111111; start = 1'b1; shft = 1'b0;
        step();
        total++;
        if (q_log !== 8'hFE || q_rot !== 8'hFE) begin
            bad++; $display("FAIL prio_preload log=%h rot=%h expected fe", q_log, q_rot);
        end
        N = 7'b0000001; start = 1'b1; shft = 1'b1;
        step();
        start = 1'b0; shft = 1'b0;
        total++;
        if (q_log !== 8'b00000010 || q_rot !== 8'b00000010) begin
            bad++; $display("FAIL prio_load_wins log=%b rot=%b expected 00000010", q_log, q_rot);
        end
    endtask

    task automatic test_reset_mid();
        N = 7'b1111111; start = 1'b1;
        step();
        start = 1'b0; shft = 1'b1;
        step();
        step();
        shft = 1'b0;
        total++;
        if (q_log !== 8'h3F || q_rot !== 8'hBF) begin
            bad++; $display("FAIL mid_pre log=%h rot=%h expected 3f/bf", q_log, q_rot);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (q_log !== 8'h00 || q_rot !== 8'h00) begin
            bad++; $display("FAIL mid_async log=%h rot=%h expected 00", q_log, q_rot);
        end
        #1;
        rst_n = 1'b1;
        shft = 1'b1;
        step();
        shft = 1'b0;
        total++;
        if (q_log !== 8'h00 || q_rot !== 8'h00) begin
            bad++; $display("FAIL mid_shift_after log=%h rot=%h expected 00", q_log, q_rot);
        end
        N = 7'b1011001; start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (q_log !== 8'hB2 || q_rot !== 8'hB2) begin
            bad++; $display("FAIL mid_reload log=%h rot=%h expected b2", q_log, q_rot);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_logical_shift();
        test_rotate();
        test_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shft_reg_8bit
